proc_datapath: RTL

Register-transfer datapath for the 16-bit multicycle processor, directly downstream of the control FSM. It holds R0–R7 (R5 = SP, R6 = LR, R7 = PC), IR, A, G, flags, ADDR, DOUT and W. It drives a single 16-bit bus through a `sel` mux and performs add/sub, AND, and shift/rotate. It returns `IR_out` and `flag_out` to the FSM and presents ADDR/DOUT/W to the memory/IO bus.

---
 rtl/proc_datapath.sv | 139 +++++++++++++
 1 files changed

// File: rtl/proc_datapath.sv
// Register-transfer datapath for the 16-bit multicycle processor: register file,
// IR/A/G/flags, a single shared bus, the ALU and the memory-side ADDR/DOUT/W registers.
module proc_datapath #(
    parameter int              DATA_W   = 16,
    parameter logic [15:0]     SP_RESET = 16'h0100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] DIN,
    input  logic [3:0]        sel,
    input  logic [7:0]        RX_in,
    input  logic              IR_in,
    input  logic              A_in,
    input  logic              G_in,
    input  logic              flag_in,
    input  logic              ADDR_in,
    input  logic              DOUT_in,
    input  logic              W_inp,
    input  logic [1:0]        op,
    input  logic              add_sub_ctrl,
    input  logic [1:0]        shift_rot_type,
    input  logic              pc_incr,
    input  logic              sp_incr,
    input  logic              sp_decr,
    output logic [DATA_W-1:0] IR_out,
    output logic [2:0]        flag_out,
    output logic [DATA_W-1:0] ADDR,
    output logic [DATA_W-1:0] DOUT,
    output logic              W,
    output logic [DATA_W-1:0] bus_dbg
);

    typedef logic [DATA_W-1:0] word_t;
    localparam word_t ONE = word_t'(1);

    word_t       r_rf [8];
    word_t       r_ir;
    word_t       r_a;
    word_t       r_g;
    logic [2:0]  r_flags;
    word_t       r_addr;
    word_t       r_dout;
    logic        r_w;

    word_t       w_bus;
    word_t       w_imm;
    logic [DATA_W:0] w_sum;
    word_t       w_alu_res;
    logic        w_arith;

    // Barrel shifter; ror takes the low half of the doubled word shifted right.
    function automatic word_t shift_rot(input word_t a, input logic [3:0] amt,
                                        input logic [1:0] kind);
        logic signed [DATA_W-1:0] a_s;
        logic [2*DATA_W-1:0]      dbl;
        a_s = a;
        dbl = {a, a} >> amt;
        case (kind)
            2'b00:   shift_rot = a << amt;
            2'b01:   shift_rot = a >> amt;
            2'b10:   shift_rot = a_s >>> amt;
            default: shift_rot = dbl[DATA_W-1:0];
        endcase
    endfunction

    always_comb begin
        w_imm = {{(DATA_W-9){1'b0}}, r_ir[8:0]};
        if (r_ir[15:13] == 3'b001) begin
            if (r_ir[12]) w_imm = {r_ir[7:0], 8'h00};
            else          w_imm = {{(DATA_W-9){r_ir[8]}}, r_ir[8:0]};
        end
    end

    always_comb begin
        w_bus = '0;
        if (!sel[3]) begin
            w_bus = r_rf[sel[2:0]];
        end else begin
            case (sel[2:0])
                3'd0:    w_bus = w_imm;
                3'd1:    w_bus = r_g;
                3'd2:    w_bus = DIN;
                default: w_bus = '0;
            endcase
        end
    end

    // Subtraction is A + ~bus + 1, so carry out of bit 16 means "no borrow".
    always_comb begin
        w_arith = (op[1] == op[0]);
        if (add_sub_ctrl) w_sum = {1'b0, r_a} + {1'b0, ~w_bus} + {{DATA_W{1'b0}}, 1'b1};
        else              w_sum = {1'b0, r_a} + {1'b0, w_bus};
        case (op)
            2'b01:   w_alu_res = r_a & w_bus;
            2'b10:   w_alu_res = shift_rot(r_a, w_bus[3:0], shift_rot_type);
            default: w_alu_res = w_sum[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) r_rf[i] <= (i == 5) ? SP_RESET : '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_flags <= 3'b000;
            r_addr  <= '0;
            r_dout  <= '0;
            r_w     <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!RX_in[i]) r_rf[i] <= w_bus;
            end
            if (RX_in[7] && pc_incr) r_rf[7] <= r_rf[7] + ONE;
            // Simultaneous increment and decrement cancel out.
            if (RX_in[5] && (sp_incr ^ sp_decr))
                r_rf[5] <= sp_incr ? r_rf[5] + ONE : r_rf[5] - ONE;
            if (!IR_in)   r_ir   <= DIN;
            if (!A_in)    r_a    <= w_bus;
            if (!G_in)    r_g    <= w_alu_res;
            if (!ADDR_in) r_addr <= w_bus;
            if (!DOUT_in) r_dout <= w_bus;
            if (!flag_in) begin
                r_flags[1] <= w_alu_res[DATA_W-1];
                r_flags[0] <= (w_alu_res == '0);
                if (w_arith) r_flags[2] <= w_sum[DATA_W];
            end
            r_w <= W_inp;
        end
    end

    assign IR_out   = r_ir;
    assign flag_out = r_flags;
    assign ADDR     = r_addr;
    assign DOUT     = r_dout;
    assign W        = r_w;
    assign bus_dbg  = w_bus;

endmodule
